axi_rr_arbiter_n: RTL and testbench

//  N-master to single-AXI4-master arbiter; generalises the fixed IFU/LSU two-port arbiter.

---
 rtl/axi_rr_arbiter_n.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_rr_arbiter_n.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter_n.sv
// Round-robin arbiter multiplexing N client masters onto a single AXI4 master port.
// Read and write paths arbitrate independently, each with its own rotating priority pointer.
module axi_rr_arbiter_n #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_MST-1:0]          m_r_valid,
  input  logic [N_MST*ADDR_W-1:0]   m_r_addr,
  input  logic [N_MST*3-1:0]        m_r_size,
  input  logic [N_MST*LEN_W-1:0]    m_r_len,
  output logic [N_MST-1:0]          m_r_ready,
  output logic [DATA_W-1:0]         m_r_data,
  output logic                      m_r_last,
  output logic                      m_r_err,
  input  logic [N_MST-1:0]          m_w_valid,
  input  logic [N_MST*ADDR_W-1:0]   m_w_addr,
  input  logic [N_MST*3-1:0]        m_w_size,
  input  logic [N_MST*LEN_W-1:0]    m_w_len,
  input  logic [N_MST*DATA_W-1:0]   m_w_data,
  input  logic [N_MST*STRB_W-1:0]   m_w_strb,
  output logic [N_MST-1:0]          m_w_ready,
  output logic [N_MST-1:0]          m_w_done,
  output logic                      m_w_err,
  output logic                      axi_ar_valid,
  output logic [ADDR_W-1:0]         axi_ar_addr,
  output logic [ID_W-1:0]           axi_ar_id,
  output logic [LEN_W-1:0]          axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  input  logic                      axi_ar_ready,
  input  logic                      axi_r_valid,
  input  logic [DATA_W-1:0]         axi_r_data,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [ID_W-1:0]           axi_r_id,
  output logic                      axi_r_ready,
  output logic                      axi_aw_valid,
  output logic [ADDR_W-1:0]         axi_aw_addr,
  output logic [ID_W-1:0]           axi_aw_id,
  output logic [LEN_W-1:0]          axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  input  logic                      axi_aw_ready,
  output logic                      axi_w_valid,
  output logic [DATA_W-1:0]         axi_w_data,
  output logic [STRB_W-1:0]         axi_w_strb,
  output logic                      axi_w_last,
  input  logic                      axi_w_ready,
  input  logic                      axi_b_valid,
  input  logic [1:0]                axi_b_resp,
  input  logic [ID_W-1:0]           axi_b_id,
  output logic                      axi_b_ready
);
  localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;

  // First requester strictly after ptr, wrapping modulo N_MST.
  function automatic logic [GW-1:0] rr_pick(input logic [N_MST-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_MST; k++) begin
      idx = (int'(ptr) + k) % N_MST;
      if (!found && req[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [ADDR_W-1:0] r_addr_arr [N_MST];
  logic [2:0]        r_size_arr [N_MST];
  logic [LEN_W-1:0]  r_len_arr  [N_MST];
  logic [ADDR_W-1:0] w_addr_arr [N_MST];
  logic [2:0]        w_size_arr [N_MST];
  logic [LEN_W-1:0]  w_len_arr  [N_MST];
  logic [DATA_W-1:0] w_data_arr [N_MST];
  logic [STRB_W-1:0] w_strb_arr [N_MST];

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  rd_state_t         rd_state_reg, rd_state_next;
  logic [GW-1:0]     rd_grant_reg, rd_grant_next, rd_ptr_reg, rd_ptr_next, rd_pick;
  logic [ADDR_W-1:0] ar_addr_reg, ar_addr_next;
  logic [2:0]        ar_size_reg, ar_size_next;
  logic [LEN_W-1:0]  ar_len_reg, ar_len_next;
  logic              rd_beat;

  wr_state_t         wr_state_reg, wr_state_next;
  logic [GW-1:0]     wr_grant_reg, wr_grant_next, wr_ptr_reg, wr_ptr_next, wr_pick;
  logic [ADDR_W-1:0] aw_addr_reg, aw_addr_next;
  logic [2:0]        aw_size_reg, aw_size_next;
  logic [LEN_W-1:0]  aw_len_reg, aw_len_next;
  logic [LEN_W-1:0]  wr_cnt_reg, wr_cnt_next;
  logic              wr_beat, wr_done;

  for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
    assign r_addr_arr[gi] = m_r_addr[gi*ADDR_W +: ADDR_W];
    assign r_size_arr[gi] = m_r_size[gi*3 +: 3];
    assign r_len_arr[gi]  = m_r_len[gi*LEN_W +: LEN_W];
    assign w_addr_arr[gi] = m_w_addr[gi*ADDR_W +: ADDR_W];
    assign w_size_arr[gi] = m_w_size[gi*3 +: 3];
    assign w_len_arr[gi]  = m_w_len[gi*LEN_W +: LEN_W];
    assign w_data_arr[gi] = m_w_data[gi*DATA_W +: DATA_W];
    assign w_strb_arr[gi] = m_w_strb[gi*STRB_W +: STRB_W];
    assign m_r_ready[gi]  = rd_beat && (rd_grant_reg == GW'(gi));
    assign m_w_ready[gi]  = wr_beat && (wr_grant_reg == GW'(gi));
    assign m_w_done[gi]   = wr_done && (wr_grant_reg == GW'(gi));
  end

  assign rd_pick = rr_pick(m_r_valid, rd_ptr_reg);
  assign wr_pick = rr_pick(m_w_valid, wr_ptr_reg);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_state_reg <= R_IDLE;
      rd_grant_reg <= '0;
      rd_ptr_reg   <= GW'(N_MST - 1);
      ar_addr_reg  <= '0;
      ar_size_reg  <= '0;
      ar_len_reg   <= '0;
      wr_state_reg <= W_IDLE;
      wr_grant_reg <= '0;
      wr_ptr_reg   <= GW'(N_MST - 1);
      aw_addr_reg  <= '0;
      aw_size_reg  <= '0;
      aw_len_reg   <= '0;
      wr_cnt_reg   <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_grant_reg <= rd_grant_next;
      rd_ptr_reg   <= rd_ptr_next;
      ar_addr_reg  <= ar_addr_next;
      ar_size_reg  <= ar_size_next;
      ar_len_reg   <= ar_len_next;
      wr_state_reg <= wr_state_next;
      wr_grant_reg <= wr_grant_next;
      wr_ptr_reg   <= wr_ptr_next;
      aw_addr_reg  <= aw_addr_next;
      aw_size_reg  <= aw_size_next;
      aw_len_reg   <= aw_len_next;
      wr_cnt_reg   <= wr_cnt_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_grant_next = rd_grant_reg;
    rd_ptr_next   = rd_ptr_reg;
    ar_addr_next  = ar_addr_reg;
    ar_size_next  = ar_size_reg;
    ar_len_next   = ar_len_reg;
    axi_ar_valid  = 1'b0;
    axi_r_ready   = 1'b0;
    rd_beat       = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (|m_r_valid) begin
          rd_grant_next = rd_pick;
          ar_addr_next  = r_addr_arr[rd_pick];
          ar_size_next  = r_size_arr[rd_pick];
          ar_len_next   = r_len_arr[rd_pick];
          rd_state_next = R_AR;
        end
      end
      R_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) rd_state_next = R_DATA;
      end
      R_DATA: begin
        axi_r_ready = 1'b1;
        rd_beat     = axi_r_valid;
        if (axi_r_valid && axi_r_last) begin
          rd_ptr_next   = rd_grant_reg;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_grant_next = wr_grant_reg;
    wr_ptr_next   = wr_ptr_reg;
    aw_addr_next  = aw_addr_reg;
    aw_size_next  = aw_size_reg;
    aw_len_next   = aw_len_reg;
    wr_cnt_next   = wr_cnt_reg;
    axi_aw_valid  = 1'b0;
    axi_w_valid   = 1'b0;
    axi_b_ready   = 1'b0;
    wr_beat       = 1'b0;
    wr_done       = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        if (|m_w_valid) begin
          wr_grant_next = wr_pick;
          aw_addr_next  = w_addr_arr[wr_pick];
          aw_size_next  = w_size_arr[wr_pick];
          aw_len_next   = w_len_arr[wr_pick];
          wr_cnt_next   = '0;
          wr_state_next = W_AW;
        end
      end
      W_AW: begin
        axi_aw_valid = 1'b1;
        if (axi_aw_ready) wr_state_next = W_DATA;
      end
      W_DATA: begin
        axi_w_valid = 1'b1;
        wr_beat     = axi_w_ready;
        if (axi_w_ready) begin
          wr_cnt_next = wr_cnt_reg + 1'b1;
          if (axi_w_last) wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
          wr_done       = 1'b1;
          wr_ptr_next   = wr_grant_reg;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  assign axi_ar_addr  = ar_addr_reg;
  assign axi_ar_id    = ID_W'(rd_grant_reg);
  assign axi_ar_len   = ar_len_reg;
  assign axi_ar_size  = ar_size_reg;
  assign axi_ar_burst = 2'b01;
  assign m_r_data     = axi_r_data;
  assign m_r_last     = axi_r_last;
  // An ID mismatch means the slave returned a beat for someone else; flag it like a bus error.
  assign m_r_err      = (axi_r_resp != 2'b00) || (axi_r_id != ID_W'(rd_grant_reg));

  assign axi_aw_addr  = aw_addr_reg;
  assign axi_aw_id    = ID_W'(wr_grant_reg);
  assign axi_aw_len   = aw_len_reg;
  assign axi_aw_size  = aw_size_reg;
  assign axi_aw_burst = 2'b01;
  assign axi_w_data   = w_data_arr[wr_grant_reg];
  assign axi_w_strb   = w_strb_arr[wr_grant_reg];
  assign axi_w_last   = (wr_cnt_reg == aw_len_reg);
  assign m_w_err      = (axi_b_resp != 2'b00) || (axi_b_id != ID_W'(wr_grant_reg));

endmodule

// File: tb/tb_axi_rr_arbiter_n.sv
// Bench for axi_rr_arbiter_n: bench plays both the client masters and the AXI slave,
// checking grants, beat routing and completion against a round-robin reference.
module tb_axi_rr_arbiter_n;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]    m_r_valid, m_r_ready, m_w_valid, m_w_ready, m_w_done;
  logic [N*AW-1:0] m_r_addr, m_w_addr;
  logic [N*3-1:0]  m_r_size, m_w_size;
  logic [N*LW-1:0] m_r_len, m_w_len;
  logic [N*DW-1:0] m_w_data;
  logic [N*SW-1:0] m_w_strb;
  logic [DW-1:0]   m_r_data, axi_r_data, axi_w_data;
  logic            m_r_last, m_r_err, m_w_err;
  logic            axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_last, axi_r_ready;
  logic            axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_last, axi_w_ready;
  logic            axi_b_valid, axi_b_ready;
  logic [AW-1:0]   axi_ar_addr, axi_aw_addr;
  logic [IW-1:0]   axi_ar_id, axi_r_id, axi_aw_id, axi_b_id;
  logic [LW-1:0]   axi_ar_len, axi_aw_len;
  logic [2:0]      axi_ar_size, axi_aw_size;
  logic [1:0]      axi_ar_burst, axi_aw_burst, axi_r_resp, axi_b_resp;
  logic [SW-1:0]   axi_w_strb;

  axi_rr_arbiter_n #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset),
    .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_size(m_r_size), .m_r_len(m_r_len),
    .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_err(m_r_err),
    .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_size(m_w_size), .m_w_len(m_w_len),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_ready(m_w_ready), .m_w_done(m_w_done),
    .m_w_err(m_w_err),
    .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr), .axi_ar_id(axi_ar_id),
    .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_valid(axi_r_valid), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_id(axi_r_id), .axi_r_ready(axi_r_ready),
    .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr), .axi_aw_id(axi_aw_id),
    .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_valid(axi_w_valid), .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
    .axi_w_last(axi_w_last), .axi_w_ready(axi_w_ready),
    .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp), .axi_b_id(axi_b_id),
    .axi_b_ready(axi_b_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] r_pend, w_pend;
  logic [AW-1:0] r_addr [N];
  logic [2:0]    r_size [N];
  logic [LW-1:0] r_len  [N];
  logic [AW-1:0] w_addr [N];
  logic [2:0]    w_size [N];
  logic [LW-1:0] w_len  [N];
  logic [DW-1:0] w_base [N];
  logic [SW-1:0] w_strb [N];
  int            w_beat [N];
  int            rd_mptr, wr_mptr;

  typedef struct {
    logic [N-1:0] pat;
    logic [LW-1:0] len;
    logic [1:0]   rresp;
    bit           idbad;
    int           exp_g;
    bit           exp_err;
  } rd_vec_t;
  rd_vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Round-robin rule: first pending master strictly after the last one served.
  function automatic int exp_grant(input logic [N-1:0] pend, input int ptr);
    for (int k = 1; k <= N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic drive_r();
    m_r_valid = r_pend;
    for (int i = 0; i < N; i++) begin
      m_r_addr[i*AW +: AW] = r_addr[i];
      m_r_size[i*3 +: 3]   = r_size[i];
      m_r_len[i*LW +: LW]  = r_len[i];
    end
  endtask

  task automatic drive_w();
    m_w_valid = w_pend;
    for (int i = 0; i < N; i++) begin
      m_w_addr[i*AW +: AW] = w_addr[i];
      m_w_size[i*3 +: 3]   = w_size[i];
      m_w_len[i*LW +: LW]  = w_len[i];
      m_w_data[i*DW +: DW] = w_base[i] + 64'(w_beat[i]);
      m_w_strb[i*SW +: SW] = w_strb[i];
    end
  endtask

  task automatic rd_txn(input int g, input logic [63:0] dbase, input logic [1:0] resp_d,
                        input bit idbad_d, input bit err_d, input bit rnd);
    int gp, len;
    logic [1:0] rs;
    bit ib;
    logic [N-1:0] er;
    len = int'(r_len[g]);
    drive_r();
    @(negedge clock);
    check("ar_latency", axi_ar_valid, 0);
    nxt();
    gp = rnd ? $urandom_range(0, 2) : 0;
    for (int k = 0; k <= gp; k++) begin
      axi_ar_ready = (k == gp);
      @(negedge clock);
      check("arvalid", axi_ar_valid, 1);
      check("arid", axi_ar_id, 64'(g));
      check("araddr", axi_ar_addr, r_addr[g]);
      check("arlen", axi_ar_len, r_len[g]);
      check("arsize", axi_ar_size, r_size[g]);
      check("arburst", axi_ar_burst, 1);
      check("rready_early", axi_r_ready, 0);
      nxt();
    end
    axi_ar_ready = 1'b0;
    for (int b = 0; b <= len; b++) begin
      gp = rnd ? $urandom_range(0, 2) : 0;
      for (int k = 0; k <= gp; k++) begin
        rs = rnd ? (($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00) : resp_d;
        ib = rnd ? ($urandom_range(0, 7) == 0) : idbad_d;
        axi_r_valid = (k == gp);
        axi_r_data  = dbase + 64'(b);
        axi_r_last  = (b == len);
        axi_r_resp  = rs;
        axi_r_id    = ib ? IW'(g ^ 1) : IW'(g);
        er = (k == gp) ? (N'(1) << g) : '0;
        @(negedge clock);
        check("rready", axi_r_ready, 1);
        check("m_r_ready", m_r_ready, er);
        if (k == gp) begin
          check("m_r_data", m_r_data, dbase + 64'(b));
          check("m_r_last", m_r_last, b == len);
          check("m_r_err", m_r_err, rnd ? ((rs != 2'b00) || ib) : err_d);
        end
        nxt();
      end
    end
    axi_r_valid = 1'b0;
    axi_r_last  = 1'b0;
    r_pend[g]   = 1'b0;
    drive_r();
    rd_mptr = g;
    $display("read  txn master %0d len %0d", g, len);
  endtask

  task automatic wr_txn(input int g, input int stall_beat, input int stall_n, input logic [1:0] bresp_d,
                        input bit bidbad_d, input bit err_d, input bit rnd);
    int gp, len;
    logic [1:0] rs;
    bit ib;
    logic [N-1:0] er;
    len = int'(w_len[g]);
    drive_w();
    @(negedge clock);
    check("aw_latency", axi_aw_valid, 0);
    nxt();
    gp = rnd ? $urandom_range(0, 2) : 0;
    for (int k = 0; k <= gp; k++) begin
      axi_aw_ready = (k == gp);
      @(negedge clock);
      check("awvalid", axi_aw_valid, 1);
      check("awid", axi_aw_id, 64'(g));
      check("awaddr", axi_aw_addr, w_addr[g]);
      check("awlen", axi_aw_len, w_len[g]);
      check("awsize", axi_aw_size, w_size[g]);
      check("awburst", axi_aw_burst, 1);
      check("wvalid_early", axi_w_valid, 0);
      nxt();
    end
    axi_aw_ready = 1'b0;
    for (int b = 0; b <= len; b++) begin
      gp = rnd ? $urandom_range(0, 2) : ((b == stall_beat) ? stall_n : 0);
      for (int k = 0; k <= gp; k++) begin
        axi_w_ready = (k == gp);
        drive_w();
        er = (k == gp) ? (N'(1) << g) : '0;
        @(negedge clock);
        check("wvalid", axi_w_valid, 1);
        check("wdata", axi_w_data, w_base[g] + 64'(b));
        check("wstrb", axi_w_strb, w_strb[g]);
        check("wlast", axi_w_last, b == len);
        check("m_w_ready", m_w_ready, er);
        nxt();
      end
      w_beat[g]++;
    end
    axi_w_ready = 1'b0;
    gp = rnd ? $urandom_range(0, 2) : 0;
    for (int k = 0; k <= gp; k++) begin
      rs = rnd ? (($urandom_range(0, 4) == 0) ? 2'b11 : 2'b00) : bresp_d;
      ib = rnd ? ($urandom_range(0, 5) == 0) : bidbad_d;
      axi_b_valid = (k == gp);
      axi_b_resp  = rs;
      axi_b_id    = ib ? IW'(g ^ 1) : IW'(g);
      er = (k == gp) ? (N'(1) << g) : '0;
      @(negedge clock);
      check("bready", axi_b_ready, 1);
      check("wvalid_in_resp", axi_w_valid, 0);
      check("m_w_done", m_w_done, er);
      if (k == gp) check("m_w_err", m_w_err, rnd ? ((rs != 2'b00) || ib) : err_d);
      nxt();
    end
    axi_b_valid = 1'b0;
    w_pend[g]   = 1'b0;
    w_beat[g]   = 0;
    drive_w();
    wr_mptr = g;
    $display("write txn master %0d len %0d", g, len);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arvalid"}, axi_ar_valid, 0);
    check({tag, "_rready"}, axi_r_ready, 0);
    check({tag, "_m_r_ready"}, m_r_ready, 0);
    check({tag, "_awvalid"}, axi_aw_valid, 0);
    check({tag, "_wvalid"}, axi_w_valid, 0);
    check({tag, "_bready"}, axi_b_ready, 0);
    check({tag, "_m_w_ready"}, m_w_ready, 0);
    check({tag, "_m_w_done"}, m_w_done, 0);
  endtask

  task automatic new_rreq(input int i);
    r_pend[i] = 1'b1;
    r_addr[i] = $urandom;
    r_size[i] = 3'($urandom_range(0, 3));
    r_len[i]  = LW'($urandom_range(0, 5));
  endtask

  task automatic new_wreq(input int i);
    w_pend[i] = 1'b1;
    w_addr[i] = $urandom;
    w_size[i] = 3'($urandom_range(0, 3));
    w_len[i]  = LW'($urandom_range(0, 5));
    w_base[i] = {$urandom, $urandom};
    w_strb[i] = SW'($urandom);
    w_beat[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 8'd0, 2'b00, 1'b0, 0, 1'b0};
    tbl[1] = '{2'b11, 8'd1, 2'b00, 1'b0, 1, 1'b0};
    tbl[2] = '{2'b11, 8'd0, 2'b00, 1'b0, 0, 1'b0};
    tbl[3] = '{2'b11, 8'd2, 2'b00, 1'b0, 1, 1'b0};
    tbl[4] = '{2'b10, 8'd1, 2'b10, 1'b0, 1, 1'b1};
    tbl[5] = '{2'b10, 8'd0, 2'b00, 1'b1, 1, 1'b1};
    tbl[6] = '{2'b01, 8'd0, 2'b00, 1'b0, 0, 1'b0};
    tbl[7] = '{2'b01, 8'd0, 2'b11, 1'b0, 0, 1'b1};
    tbl[8] = '{2'b11, 8'd0, 2'b00, 1'b0, 1, 1'b0};

    reset = 1'b0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = '0; axi_r_resp = 0; axi_r_last = 0; axi_r_id = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0;
    r_pend = '0; w_pend = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_size[i] = '0; r_len[i] = '0;
      w_addr[i] = '0; w_size[i] = '0; w_len[i] = '0; w_base[i] = '0; w_strb[i] = '0; w_beat[i] = 0;
    end
    drive_r();
    drive_w();
    repeat (3) nxt();
    @(negedge clock);
    check_idle_outputs("reset");
    nxt();
    reset = 1'b1;
    rd_mptr = N - 1;
    wr_mptr = N - 1;

    // Table: read arbitration order and error flagging.
    for (int e = 0; e < 9; e++) begin
      r_pend = tbl[e].pat;
      for (int i = 0; i < N; i++) begin
        r_addr[i] = 32'h1000_0000 * 32'(i + 1) + 32'(e * 256);
        r_size[i] = 3'd3;
        r_len[i]  = tbl[e].len;
      end
      rd_txn(tbl[e].exp_g, 64'h1111_0000_0000_0000 + 64'(e * 16), tbl[e].rresp,
             tbl[e].idbad, tbl[e].exp_err, 1'b0);
    end

    // Single-beat read from master 0.
    r_pend = 2'b01;
    r_addr[0] = 32'h8000_0000; r_len[0] = 8'd0; r_size[0] = 3'd2;
    rd_txn(0, 64'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0);

    // Master 1 four-beat write stalled two cycles on the second beat.
    w_pend = 2'b10;
    w_addr[1] = 32'h0F00_0000; w_len[1] = 8'd3; w_size[1] = 3'd3;
    w_base[1] = 64'hA5A5_0000_0000_1000; w_strb[1] = 8'hF0; w_beat[1] = 0;
    wr_txn(1, 1, 2, 2'b00, 1'b0, 1'b0, 1'b0);

    // bid returned as 0 while master 1 owns the write path.
    w_pend = 2'b10; w_len[1] = 8'd0; w_base[1] = 64'h0BAD_0000_0000_0000;
    wr_txn(1, -1, 0, 2'b00, 1'b1, 1'b1, 1'b0);

    // Both masters write; pointer sits at 1 so master 0 wins, then master 1.
    w_pend = 2'b11;
    for (int i = 0; i < N; i++) begin
      w_addr[i] = 32'h4000_0000 + 32'(i * 64); w_len[i] = 8'd1; w_size[i] = 3'd3;
      w_base[i] = 64'h7700_0000_0000_0000 + 64'(i * 32'h100); w_strb[i] = 8'hFF; w_beat[i] = 0;
    end
    wr_txn(0, -1, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    wr_txn(1, -1, 0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Concurrent read burst on master 0 and write on master 1.
    r_pend = 2'b01; r_addr[0] = 32'h0000_4000; r_len[0] = 8'd7; r_size[0] = 3'd3;
    w_pend = 2'b10; w_addr[1] = 32'h0000_8000; w_len[1] = 8'd1; w_base[1] = 64'hC0DE_0000_0000_0000;
    w_strb[1] = 8'h0F; w_beat[1] = 0;
    fork
      rd_txn(0, 64'h5555_0000_0000_0000, 2'b00, 1'b0, 1'b0, 1'b0);
      wr_txn(1, -1, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    join

    // Random traffic on both paths against the round-robin reference.
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          for (int i = 0; i < N; i++) if (!r_pend[i] && $urandom_range(0, 1) == 1) new_rreq(i);
          if (r_pend == '0) new_rreq($urandom_range(0, N - 1));
          rd_txn(exp_grant(r_pend, rd_mptr), {$urandom, $urandom}, 2'b00, 1'b0, 1'b0, 1'b1);
        end
        r_pend = '0;
        drive_r();
      end
      begin
        for (int t = 0; t < 30; t++) begin
          for (int i = 0; i < N; i++) if (!w_pend[i] && $urandom_range(0, 1) == 1) new_wreq(i);
          if (w_pend == '0) new_wreq($urandom_range(0, N - 1));
          wr_txn(exp_grant(w_pend, wr_mptr), -1, 0, 2'b00, 1'b0, 1'b0, 1'b1);
        end
        w_pend = '0;
        drive_w();
      end
    join
    nxt();

    // Reset after the second beat of a four-beat read.
    r_pend = 2'b01; r_addr[0] = 32'h2000_0000; r_len[0] = 8'd3; r_size[0] = 3'd3;
    drive_r();
    nxt();
    axi_ar_ready = 1'b1;
    nxt();
    axi_ar_ready = 1'b0;
    axi_r_valid = 1'b1; axi_r_last = 1'b0; axi_r_resp = 2'b00; axi_r_id = '0;
    for (int b = 0; b < 2; b++) begin
      axi_r_data = 64'h9000 + 64'(b);
      @(negedge clock);
      check("rst_pre_m_r_ready", m_r_ready, 2'b01);
      check("rst_pre_m_r_data", m_r_data, 64'h9000 + 64'(b));
      nxt();
    end
    reset = 1'b0;
    nxt();
    @(negedge clock);
    check_idle_outputs("abort");
    nxt();
    axi_r_valid = 1'b0;
    reset = 1'b1;
    rd_mptr = N - 1;
    wr_mptr = N - 1;
    r_pend = 2'b11;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 32'h3000_0000 + 32'(i * 16); r_len[i] = 8'd0; r_size[i] = 3'd2;
    end
    rd_txn(0, 64'h1234, 2'b00, 1'b0, 1'b0, 1'b0);
    rd_txn(1, 64'h5678, 2'b00, 1'b0, 1'b0, 1'b0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
